// File: rtl/mult_display_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mult_display_pkg
// Purpose : Shared types and constants for the multiplier display scanner:
//           character codes, FSM state encoding and 7-seg patterns.
// Rev     : 1.0  initial release
// ============================================================================
package mult_display_pkg;

  // 4-bit display character code: 0-9 are digits, the rest are symbols
  typedef logic [3:0] char_t;

  localparam char_t CH_E     = 4'd10;
  localparam char_t CH_DASH  = 4'd11;
  localparam char_t CH_BLANK = 4'd15;

  // Conversion FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  // Active-high segment patterns {a,b,c,d,e,f,g,dp}; dp is never lit
  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_E     = 8'h9E;
  localparam logic [7:0] SEG_DASH  = 8'h02;
  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage : mult_display_pkg
`default_nettype wire

// File: rtl/mult_display_scan_decode.sv
`default_nettype none
// ============================================================================
// Module  : seg_char_decode
// Purpose : Combinational character-code to 7-segment pattern decoder.
//           Unused codes (12-15) decode to a dark digit.
// Rev     : 1.0  initial release
// ============================================================================
module seg_char_decode
  import mult_display_pkg::*;
(
  input  char_t      code_i,
  output logic [7:0] seg_o
);

  // Table lookup of the segment pattern for one character
  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      CH_E:    seg_o = SEG_E;
      CH_DASH: seg_o = SEG_DASH;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule : seg_char_decode
`default_nettype wire

// File: rtl/mult_display_scan.sv
`default_nettype none
// ============================================================================
// Module  : mult_display_scan
// Purpose : Accepts a product over valid/ready, converts it to BCD with a
//           bit-serial shift-add-3 loop, loads NDIG display characters
//           (numeric or error) and time-multiplexes them onto the 7-seg pins.
//           et enables the external counter only while a settled value is
//           shown.
// Config  : `define LEAD_ZERO_BLANK_EN to blank leading zero digits;
//           otherwise every digit shows its BCD value.
// Rev     : 1.0  initial release
// ============================================================================
module mult_display_scan
  import mult_display_pkg::*;
#(
  parameter int PW          = 8,
  parameter int NDIG        = 4,
  parameter int MAX_VALID   = 225,
  parameter int REFRESH_DIV = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pr_valid,
  input  logic [PW-1:0]   pr,
  output logic            pr_ready,
  output logic [7:0]      seg,
  output logic [NDIG-1:0] an,
  output logic            et,
  output logic            busy
);

  localparam int BW = 4 * NDIG;
  localparam int CW = (PW > 1) ? $clog2(PW) : 1;
  localparam int IW = $clog2(NDIG);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [PW-1:0] MAX_C      = PW'(MAX_VALID);
  localparam logic [CW-1:0] BIT_LAST   = CW'(PW - 1);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

  // Conversion state
  state_e              state_q;
  logic                pr_ready_q;
  logic                busy_q;
  logic                et_q;
  logic                err_q;
  logic [PW-1:0]       sreg_q;
  logic [BW-1:0]       bcd_q;
  logic [CW-1:0]       bitcnt_q;
  logic [NDIG-1:0][3:0] disp_q;

  // Scanner state
  logic [RW-1:0]       refcnt_q;
  logic [IW-1:0]       idx_q;
  logic [NDIG-1:0]     an_q;
  logic [7:0]          seg_q;

  logic [BW-1:0]       bcd_adj;
  logic [BW:0]         bcd_shift;
  logic [NDIG-1:0][3:0] chars;
  char_t               scan_char;
  logic [7:0]          scan_seg;
  logic [IW-1:0]       idx_nxt;

  // Add-3 correction on every nibble that would reach 10+ after the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Shift the corrected accumulator left, pulling in the next product MSB;
  // the extra top bit is the carry out of the most significant nibble
  assign bcd_shift = {bcd_adj, sreg_q[PW-1]};

  // Character codes to load: error pattern, or BCD digits (optionally with
  // leading zeros blanked; digit 0 always shows a digit)
  always_comb begin
`ifdef LEAD_ZERO_BLANK_EN
    logic leading;
    leading = 1'b1;
`endif
    chars = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      if (err_q) begin
        chars[i] = (i == NDIG - 1) ? CH_E : CH_DASH;
      end else begin
`ifdef LEAD_ZERO_BLANK_EN
        if (leading && (bcd_q[4*i +: 4] == 4'd0) && (i != 0)) begin
          chars[i] = CH_BLANK;
        end else begin
          chars[i] = bcd_q[4*i +: 4];
          leading  = 1'b0;
        end
`else
        chars[i] = bcd_q[4*i +: 4];
`endif
      end
    end
  end

  // Conversion FSM: accept, serial BCD conversion, one-cycle display load
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      et_q       <= 1'b0;
      err_q      <= 1'b0;
      sreg_q     <= '0;
      bcd_q      <= '0;
      bitcnt_q   <= '0;
      disp_q     <= {NDIG{CH_BLANK}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pr_valid && pr_ready_q) begin
            pr_ready_q <= 1'b0;
            et_q       <= 1'b0;
            sreg_q     <= pr;
            if (pr > MAX_C) begin
              // Out-of-range products skip conversion entirely
              err_q   <= 1'b1;
              state_q <= ST_LOAD;
            end else begin
              err_q    <= 1'b0;
              bcd_q    <= '0;
              bitcnt_q <= BIT_LAST;
              busy_q   <= 1'b1;
              state_q  <= ST_CONV;
            end
          end
        end
        ST_CONV: begin
          bcd_q  <= bcd_shift[BW-1:0];
          sreg_q <= sreg_q << 1;
          if (bcd_shift[BW]) begin
            err_q <= 1'b1;
          end
          if (bitcnt_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= ST_LOAD;
          end else begin
            bitcnt_q <= bitcnt_q - 1'b1;
          end
        end
        ST_LOAD: begin
          disp_q     <= chars;
          pr_ready_q <= 1'b1;
          et_q       <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          pr_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          et_q       <= 1'b0;
        end
      endcase
    end
  end

  assign idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
  assign scan_char = disp_q[idx_q];

  seg_char_decode u_dec (
    .code_i (scan_char),
    .seg_o  (scan_seg)
  );

  // Free-running digit scanner; seg trails the anode change by one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refcnt_q <= '0;
      idx_q    <= '0;
      an_q     <= NDIG'(1);
      seg_q    <= SEG_BLANK;
    end else begin
      seg_q <= scan_seg;
      if (refcnt_q == REF_LAST) begin
        refcnt_q <= '0;
        idx_q    <= idx_nxt;
        an_q     <= NDIG'(1) << idx_nxt;
      end else begin
        refcnt_q <= refcnt_q + 1'b1;
      end
    end
  end

  assign pr_ready = pr_ready_q;
  assign busy     = busy_q;
  assign et       = et_q;
  assign an       = an_q;
  assign seg      = seg_q;

endmodule : mult_display_scan
`default_nettype wire
